// File: rtl/regstate_pkg.sv
// Shared types for the register hazard scoreboard: index/counter widths and per-entry status.
package regstate_pkg;

    localparam int unsigned REG_COUNT_DEF      = 16;
    localparam int unsigned READ_CNT_WIDTH_DEF = 4;
    localparam int unsigned REG_IDX_W          = $clog2(REG_COUNT_DEF);

    typedef logic [REG_IDX_W-1:0]          reg_idx_t;
    typedef logic [READ_CNT_WIDTH_DEF-1:0] rd_cnt_t;

    typedef struct packed {
        logic dirty;
        logic to_be_written;
        logic to_be_read;
    } reg_status_t;

endpackage

// File: rtl/register_state_entry.sv
// One scoreboard entry: Dirty, ToBeWritten and a saturating ToBeRead counter.
// ZERO_REG pins the entry to all-zero state and masks its hazard/error outputs.
module register_state_entry
    import regstate_pkg::*;
#(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned DEC_W    = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             clk_en,
    input  logic [1:0]       i_inc,
    input  logic             i_inc_acc,
    input  logic [DEC_W-1:0] i_dec,
    input  logic             i_disp_wr,
    input  logic             i_disp_mc,
    input  logic             i_load_clr,
    input  logic             i_wb_clr,
    output reg_status_t      o_status,
    output logic             o_sat,
    output logic             o_underflow
);

    localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** CNT_W) - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_dirty;
    logic                    r_tbw;
    logic [1:0]              w_inc_eff;
    logic signed [SUM_W-1:0] w_try;
    logic signed [SUM_W-1:0] w_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_set_dirty;
    logic                    w_set_tbw;

    always_comb begin
        w_inc_eff   = i_inc_acc ? i_inc : 2'b00;
        // w_try assumes the dispatch lands; it drives back-pressure independent of acceptance
        w_try       = $signed(SUM_W'(r_cnt)) + $signed(SUM_W'(i_inc)) - $signed(SUM_W'(i_dec));
        w_next      = $signed(SUM_W'(r_cnt)) + $signed(SUM_W'(w_inc_eff)) - $signed(SUM_W'(i_dec));
        w_cnt_next  = w_next[SUM_W-1] ? '0 : ((w_next > MAX_S) ? '1 : w_next[CNT_W-1:0]);
        w_set_dirty = i_disp_wr && i_disp_mc;
        w_set_tbw   = i_disp_wr && (!i_disp_mc || r_dirty);
        o_sat       = !ZERO_REG && (w_try > MAX_S);
        o_underflow = !ZERO_REG && w_next[SUM_W-1];
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_cnt   <= '0;
            r_dirty <= 1'b0;
            r_tbw   <= 1'b0;
        end else if (clk_en && !ZERO_REG) begin
            r_cnt   <= w_cnt_next;
            r_dirty <= w_set_dirty ? 1'b1 : (i_load_clr ? 1'b0 : r_dirty);
            r_tbw   <= w_set_tbw ? 1'b1 : (i_wb_clr ? 1'b0 : r_tbw);
        end
    end

    always_comb begin
        o_status.dirty         = r_dirty;
        o_status.to_be_written = r_tbw;
        o_status.to_be_read    = (r_cnt != '0);
    end

endmodule

// File: rtl/register_state_table.sv
// Register-file hazard scoreboard: decodes dispatch/issue/writeback into per-entry events.
// Define REGSTATE_ZERO_REG_EN to hardwire register 0 as an untracked zero register.
module register_state_table
    import regstate_pkg::*;
#(
    parameter int unsigned REG_COUNT      = 16,
    parameter int unsigned READ_CNT_WIDTH = 4,
    parameter int unsigned ISSUE_PORTS    = 2
) (
    input  logic                                   clk,
    input  logic                                   async_rst,
    input  logic                                   clk_en,
    input  logic                                   dispatch_valid,
    output logic                                   dispatch_ready,
    input  logic [$clog2(REG_COUNT)-1:0]           dispatch_a_idx,
    input  logic [$clog2(REG_COUNT)-1:0]           dispatch_b_idx,
    input  logic                                   dispatch_b_used,
    input  logic                                   dispatch_writes_a,
    input  logic                                   dispatch_multicycle,
    input  logic [ISSUE_PORTS-1:0]                 issue_valid,
    input  logic [ISSUE_PORTS*$clog2(REG_COUNT)-1:0] issue_a_idx,
    input  logic [ISSUE_PORTS*$clog2(REG_COUNT)-1:0] issue_b_idx,
    input  logic [ISSUE_PORTS-1:0]                 issue_b_used,
    input  logic                                   writeback_valid,
    input  logic [$clog2(REG_COUNT)-1:0]           writeback_idx,
    input  logic                                   load_valid,
    input  logic [$clog2(REG_COUNT)-1:0]           load_idx,
    output logic [REG_COUNT-1:0]                   dirty_vec,
    output logic [REG_COUNT-1:0]                   to_be_written_vec,
    output logic [REG_COUNT-1:0]                   to_be_read_vec,
    output logic                                   underflow_err
);

    localparam int unsigned IDX_W = $clog2(REG_COUNT);
    localparam int unsigned DEC_W = $clog2(2 * ISSUE_PORTS + 1);
`ifdef REGSTATE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    logic [1:0]           w_inc [REG_COUNT];
    logic [DEC_W-1:0]     w_dec [REG_COUNT];
    reg_status_t          w_status [REG_COUNT];
    logic [REG_COUNT-1:0] w_disp_wr;
    logic [REG_COUNT-1:0] w_load_clr;
    logic [REG_COUNT-1:0] w_wb_clr;
    logic [REG_COUNT-1:0] w_sat;
    logic [REG_COUNT-1:0] w_uf;
    logic                 w_accept;
    logic                 r_underflow;

    always_comb begin
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            w_inc[i]      = '0;
            w_dec[i]      = '0;
            w_load_clr[i] = load_valid && (load_idx == IDX_W'(i));
            w_wb_clr[i]   = writeback_valid && (writeback_idx == IDX_W'(i));
            if (dispatch_valid && (dispatch_a_idx == IDX_W'(i)))
                w_inc[i] = w_inc[i] + 2'd1;
            if (dispatch_valid && dispatch_b_used && (dispatch_b_idx == IDX_W'(i)))
                w_inc[i] = w_inc[i] + 2'd1;
            for (int unsigned p = 0; p < ISSUE_PORTS; p++) begin
                if (issue_valid[p] && (issue_a_idx[p*IDX_W +: IDX_W] == IDX_W'(i)))
                    w_dec[i] = w_dec[i] + DEC_W'(1);
                if (issue_valid[p] && issue_b_used[p] && (issue_b_idx[p*IDX_W +: IDX_W] == IDX_W'(i)))
                    w_dec[i] = w_dec[i] + DEC_W'(1);
            end
        end
    end

    assign dispatch_ready = ~|w_sat;
    assign w_accept       = dispatch_valid && dispatch_ready && clk_en;

    always_comb begin
        for (int unsigned i = 0; i < REG_COUNT; i++)
            w_disp_wr[i] = w_accept && dispatch_writes_a && (dispatch_a_idx == IDX_W'(i));
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_entry
        register_state_entry #(
            .CNT_W    (READ_CNT_WIDTH),
            .DEC_W    (DEC_W),
            .ZERO_REG (ZERO_REG_EN && (g == 0))
        ) u_entry (
            .clk         (clk),
            .async_rst   (async_rst),
            .clk_en      (clk_en),
            .i_inc       (w_inc[g]),
            .i_inc_acc   (dispatch_ready),
            .i_dec       (w_dec[g]),
            .i_disp_wr   (w_disp_wr[g]),
            .i_disp_mc   (dispatch_multicycle),
            .i_load_clr  (w_load_clr[g]),
            .i_wb_clr    (w_wb_clr[g]),
            .o_status    (w_status[g]),
            .o_sat       (w_sat[g]),
            .o_underflow (w_uf[g])
        );
        assign dirty_vec[g]         = w_status[g].dirty;
        assign to_be_written_vec[g] = w_status[g].to_be_written;
        assign to_be_read_vec[g]    = w_status[g].to_be_read;
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst)
            r_underflow <= 1'b0;
        else if (clk_en && (|w_uf))
            r_underflow <= 1'b1;
    end

    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_register_state_table.sv
// Directed self-checking bench for register_state_table (default parameters).
// Zero-register expectations follow REGSTATE_ZERO_REG_EN.
module tb_register_state_table;
    import regstate_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned P  = 2;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          clk_en;
    logic          dispatch_valid;
    logic          dispatch_ready;
    logic [IW-1:0] dispatch_a_idx;
    logic [IW-1:0] dispatch_b_idx;
    logic          dispatch_b_used;
    logic          dispatch_writes_a;
    logic          dispatch_multicycle;
    logic [P-1:0]  issue_valid;
    logic [P*IW-1:0] issue_a_idx;
    logic [P*IW-1:0] issue_b_idx;
    logic [P-1:0]  issue_b_used;
    logic          writeback_valid;
    logic [IW-1:0] writeback_idx;
    logic          load_valid;
    logic [IW-1:0] load_idx;
    logic [N-1:0]  dirty_vec;
    logic [N-1:0]  to_be_written_vec;
    logic [N-1:0]  to_be_read_vec;
    logic          underflow_err;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    register_state_table #(
        .REG_COUNT      (N),
        .READ_CNT_WIDTH (4),
        .ISSUE_PORTS    (P)
    ) dut (
        .clk                 (clk),
        .async_rst           (async_rst),
        .clk_en              (clk_en),
        .dispatch_valid      (dispatch_valid),
        .dispatch_ready      (dispatch_ready),
        .dispatch_a_idx      (dispatch_a_idx),
        .dispatch_b_idx      (dispatch_b_idx),
        .dispatch_b_used     (dispatch_b_used),
        .dispatch_writes_a   (dispatch_writes_a),
        .dispatch_multicycle (dispatch_multicycle),
        .issue_valid         (issue_valid),
        .issue_a_idx         (issue_a_idx),
        .issue_b_idx         (issue_b_idx),
        .issue_b_used        (issue_b_used),
        .writeback_valid     (writeback_valid),
        .writeback_idx       (writeback_idx),
        .load_valid          (load_valid),
        .load_idx            (load_idx),
        .dirty_vec           (dirty_vec),
        .to_be_written_vec   (to_be_written_vec),
        .to_be_read_vec      (to_be_read_vec),
        .underflow_err       (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dispatch_valid      = 1'b0;
        dispatch_a_idx      = '0;
        dispatch_b_idx      = '0;
        dispatch_b_used     = 1'b0;
        dispatch_writes_a   = 1'b0;
        dispatch_multicycle = 1'b0;
        issue_valid         = '0;
        issue_a_idx         = '0;
        issue_b_idx         = '0;
        issue_b_used        = '0;
        writeback_valid     = 1'b0;
        writeback_idx       = '0;
        load_valid          = 1'b0;
        load_idx            = '0;
    endtask

    task automatic disp(input reg_idx_t a, input reg_idx_t b, input logic bu,
                        input logic wr, input logic mc);
        dispatch_valid      = 1'b1;
        dispatch_a_idx      = a;
        dispatch_b_idx      = b;
        dispatch_b_used     = bu;
        dispatch_writes_a   = wr;
        dispatch_multicycle = mc;
    endtask

    task automatic iss(input int p, input reg_idx_t a, input reg_idx_t b, input logic bu);
        issue_valid[p]            = 1'b1;
        issue_a_idx[p*IW +: IW]   = a;
        issue_b_idx[p*IW +: IW]   = b;
        issue_b_used[p]           = bu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        clk_en    = 1'b1;
        async_rst = 1'b0;
        #3 async_rst = 1'b1;
        #1;
        check("rst_dirty", 32'(dirty_vec), 32'h0);
        check("rst_tbw",   32'(to_be_written_vec), 32'h0);
        check("rst_tbr",   32'(to_be_read_vec), 32'h0);
        check("rst_uf",    32'(underflow_err), 32'h0);
        check("rst_ready", 32'(dispatch_ready), 32'h1);
        @(negedge clk);
        async_rst = 1'b0;

        // single-cycle producer with two distinct readers
        disp(4'd3, 4'd5, 1'b1, 1'b1, 1'b0); tick(); idle();
        check("t1_tbw",   32'(to_be_written_vec), 32'h0008);
        check("t1_tbr",   32'(to_be_read_vec), 32'h0028);
        check("t1_dirty", 32'(dirty_vec), 32'h0);
        iss(1, 4'd3, 4'd5, 1'b1); tick(); idle();
        check("t1_rel_tbr", 32'(to_be_read_vec), 32'h0);
        check("t1_rel_uf",  32'(underflow_err), 32'h0);
        writeback_valid = 1'b1; writeback_idx = 4'd3; tick(); idle();
        check("t1_wb_tbw", 32'(to_be_written_vec), 32'h0);

        // multicycle load chain on register 7
        disp(4'd7, 4'd0, 1'b0, 1'b1, 1'b1); tick(); idle();
        check("t2_dirty", 32'(dirty_vec), 32'h0080);
        check("t2_tbw",   32'(to_be_written_vec), 32'h0);
        check("t2_tbr",   32'(to_be_read_vec), 32'h0080);
        disp(4'd7, 4'd0, 1'b0, 1'b1, 1'b1); tick(); idle();
        check("t2_waw_tbw", 32'(to_be_written_vec), 32'h0080);
        disp(4'd7, 4'd0, 1'b0, 1'b1, 1'b1); load_valid = 1'b1; load_idx = 4'd7; tick(); idle();
        check("t2_ld_col_dirty", 32'(dirty_vec), 32'h0080);
        disp(4'd7, 4'd0, 1'b0, 1'b1, 1'b0); writeback_valid = 1'b1; writeback_idx = 4'd7; tick(); idle();
        check("t2_wb_col_tbw", 32'(to_be_written_vec), 32'h0080);
        load_valid = 1'b1; load_idx = 4'd7; writeback_valid = 1'b1; writeback_idx = 4'd7; tick(); idle();
        check("t2_clr_dirty", 32'(dirty_vec), 32'h0);
        check("t2_clr_tbw",   32'(to_be_written_vec), 32'h0);
        iss(0, 4'd7, 4'd7, 1'b1); iss(1, 4'd7, 4'd7, 1'b1); tick(); idle();
        check("t2_drain_tbr", 32'(to_be_read_vec), 32'h0);
        check("t2_drain_uf",  32'(underflow_err), 32'h0);

        // clock enable low freezes all state
        clk_en = 1'b0;
        disp(4'd4, 4'd4, 1'b1, 1'b1, 1'b1); iss(0, 4'd9, 4'd0, 1'b0); tick(); idle();
        clk_en = 1'b1;
        check("t3_hold_tbr",   32'(to_be_read_vec), 32'h0);
        check("t3_hold_dirty", 32'(dirty_vec), 32'h0);
        check("t3_hold_uf",    32'(underflow_err), 32'h0);

        // counter saturation back-pressure on register 2
        for (int k = 0; k < 7; k++) begin
            disp(4'd2, 4'd2, 1'b1, 1'b0, 1'b0); tick(); idle();
        end
        check("t4_cnt14_tbr", 32'(to_be_read_vec), 32'h0004);
        disp(4'd2, 4'd2, 1'b1, 1'b0, 1'b0); #1;
        check("t4_ready_ab16", 32'(dispatch_ready), 32'h0);
        idle(); disp(4'd2, 4'd0, 1'b0, 1'b0, 1'b0); #1;
        check("t4_ready_a15", 32'(dispatch_ready), 32'h1);
        tick(); idle();
        disp(4'd2, 4'd0, 1'b0, 1'b0, 1'b0); #1;
        check("t4_ready_full", 32'(dispatch_ready), 32'h0);
        iss(0, 4'd2, 4'd0, 1'b0); #1;
        check("t4_ready_rel", 32'(dispatch_ready), 32'h1);
        tick(); idle();
        disp(4'd2, 4'd0, 1'b0, 1'b0, 1'b0); tick(); idle();
        for (int k = 0; k < 3; k++) begin
            iss(0, 4'd2, 4'd2, 1'b1); iss(1, 4'd2, 4'd2, 1'b1); tick(); idle();
        end
        check("t4_cnt3_tbr", 32'(to_be_read_vec), 32'h0004);
        iss(0, 4'd2, 4'd2, 1'b1); iss(1, 4'd2, 4'd0, 1'b0); tick(); idle();
        check("t4_cnt0_tbr", 32'(to_be_read_vec), 32'h0);
        check("t4_cnt0_uf",  32'(underflow_err), 32'h0);

        // underflow is sticky and clamps at zero
        iss(0, 4'd9, 4'd0, 1'b0); tick(); idle();
        check("t5_uf",     32'(underflow_err), 32'h1);
        check("t5_uf_tbr", 32'(to_be_read_vec), 32'h0);
        tick(); tick();
        check("t5_uf_sticky", 32'(underflow_err), 32'h1);

        // asynchronous reset in the middle of activity
        disp(4'd6, 4'd8, 1'b1, 1'b1, 1'b1); tick(); idle();
        check("t6_pre_dirty", 32'(dirty_vec), 32'h0040);
        check("t6_pre_tbr",   32'(to_be_read_vec), 32'h0140);
        #2 async_rst = 1'b1;
        #1;
        check("t6_rst_dirty", 32'(dirty_vec), 32'h0);
        check("t6_rst_tbr",   32'(to_be_read_vec), 32'h0);
        check("t6_rst_uf",    32'(underflow_err), 32'h0);
        @(negedge clk);
        async_rst = 1'b0;

        // register 0 behaviour depends on the zero-register build option
        disp(4'd0, 4'd0, 1'b1, 1'b1, 1'b1); tick(); idle();
`ifdef REGSTATE_ZERO_REG_EN
        check("t7_z_dirty", 32'(dirty_vec), 32'h0);
        check("t7_z_tbr",   32'(to_be_read_vec), 32'h0);
        disp(4'd0, 4'd0, 1'b0, 1'b1, 1'b1); tick(); idle();
        check("t7_z_tbw", 32'(to_be_written_vec), 32'h0);
        iss(0, 4'd0, 4'd0, 1'b1); tick(); idle();
        check("t7_z_uf", 32'(underflow_err), 32'h0);
`else
        check("t7_r0_dirty", 32'(dirty_vec), 32'h0001);
        check("t7_r0_tbr",   32'(to_be_read_vec), 32'h0001);
        iss(0, 4'd0, 4'd0, 1'b1); tick(); idle();
        check("t7_r0_rel_tbr", 32'(to_be_read_vec), 32'h0);
        check("t7_r0_uf",      32'(underflow_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/register_state_table.md
Name: register_state_table

Overview:
Parametrised hazard scoreboard covering the whole architectural register file. It replaces per-register single-port state cells with one table of REG_COUNT entries. Each entry tracks Dirty (pending multi-cycle load), ToBeWritten (pending single-cycle WAR/WAW producer) and a saturating ToBeRead count, which is the pending RAW readers. It sits between dispatch (runahead-queue push) and issue/writeback. New over the previous cell: multiple issue ports, indexed addressing, a saturation back-pressure signal, and a sticky underflow error.

Parameters:
REG_COUNT, 16, number of tracked registers (power of 2, >=2)
READ_CNT_WIDTH, 4, ToBeRead counter width per entry
ISSUE_PORTS, 2, number of independent issue ports that release reads

Ports:
clk  in  1  clock
async_rst  in  1  asynchronous active-high reset
clk_en  in  1  global advance enable; no state changes when low
dispatch_valid  in  1  instruction being pushed to runahead queue
dispatch_ready  out  1  low when the push would saturate a ToBeRead counter
dispatch_a_idx  in  $clog2(REG_COUNT)  A operand register
dispatch_b_idx  in  $clog2(REG_COUNT)  B operand register
dispatch_b_used  in  1  B operand is read
dispatch_writes_a  in  1  instruction writes A
dispatch_multicycle  in  1  write is a multi-cycle (load) result
issue_valid  in  ISSUE_PORTS  per-port issue strobe
issue_a_idx  in  ISSUE_PORTS*$clog2(REG_COUNT)  per-port A register, flattened
issue_b_idx  in  ISSUE_PORTS*$clog2(REG_COUNT)  per-port B register, flattened
issue_b_used  in  ISSUE_PORTS  per-port B operand read
writeback_valid, writeback_idx  in  1, $clog2(REG_COUNT)  single-cycle write completes
load_valid, load_idx  in  1, $clog2(REG_COUNT)  multi-cycle load write completes
dirty_vec  out  REG_COUNT  Dirty per register
to_be_written_vec  out  REG_COUNT  ToBeWritten per register
to_be_read_vec  out  REG_COUNT  ToBeRead counter non-zero
underflow_err  out  1  sticky; an issue released a read from a zero counter

Behaviour:
- Reset (async): all counters 0; dirty_vec, to_be_written_vec, to_be_read_vec, underflow_err = 0. Outputs are registered state; with no dispatch, dispatch_ready = 1.
- Accepted dispatch: dispatch_valid && dispatch_ready && clk_en. All updates occur on that posedge; status is visible 1 cycle later.
- Read references: A always counts +1. B counts +1 if dispatch_b_used. If A==B with B used, that register gets +2.
- Issue releases: each port p with issue_valid[p] gives -1 to A and, if issue_b_used[p], -1 to B. Ports sum; the same register may be hit by several ports.
- Per entry: next = count + inc - dec, computed at READ_CNT_WIDTH+2 bits signed.
  - Negative result: clamp to 0 and set underflow_err.
  - Saturation is prevented by dispatch_ready.
- dispatch_ready is combinational. It goes low if, for A or B, count + inc - dec > 2^READ_CNT_WIDTH-1 in the same cycle.
- to_be_read_vec[i] = (count_i != 0), taken from the registered counter.
- Dirty[A]: on an accepted dispatch with writes_a && multicycle, set to 1. On load_valid at idx, cleared. If both target the same register in the same cycle, set wins.
- ToBeWritten[A]: set on an accepted dispatch with writes_a && (!multicycle || Dirty[A]); the Dirty term covers a WAW behind an outstanding load. Cleared on writeback_valid at idx; set wins on collision.
- writes_a && multicycle with Dirty[A]=0 leaves ToBeWritten unchanged.
- clk_en=0: all state holds, dispatch_ready is still computed, underflow_err holds.
- Reset mid-operation: everything clears immediately; no pending events survive.

Optional Feature:
REGSTATE_ZERO_REG_EN.
- Defined: register 0 is hardwired zero. Its entry holds all-zero state and is excluded from dispatch_ready and underflow_err; it ignores every event.
- Undefined: register 0 is tracked like any other.

Decomposition:
- Package regstate_pkg holds:
  - localparam REG_IDX_W = $clog2(REG_COUNT) defaults
  - typedef reg_idx_t
  - typedef rd_cnt_t
  - struct reg_status_t {dirty, to_be_written, to_be_read}
- Sub-module register_state_entry: one entry with inc/dec/set/clear inputs, generated REG_COUNT times. The top module decodes indices and issue-port sums.

Test Plan:
- Reset: assert async_rst mid-cycle, no clock edge -> all vecs 0, underflow_err=0, dispatch_ready=1.
- Dispatch A=3 writes single-cycle, B=5 used -> next cycle to_be_written_vec[3]=1, to_be_read bits 3 and 5=1. Issue port1 A=3, B=5 -> both read bits 0. Writeback idx 3 -> to_be_written_vec[3]=0.
- Dispatch A=7 multicycle -> dirty_vec[7]=1, to_be_written_vec[7]=0. Dispatch A=7 multicycle again -> to_be_written_vec[7]=1. Load idx 7 plus a new multicycle dispatch A=7 in the same cycle -> dirty_vec[7] stays 1.
- Push 15 reads of reg 2 (READ_CNT_WIDTH=4) -> dispatch_ready low for A=2. Add a same-cycle issue of reg 2 on port 0 -> dispatch_ready high and the count holds at 15.
- Issue reg 9 with count 0 -> count stays 0, underflow_err=1 and stays set.
- With REGSTATE_ZERO_REG_EN: dispatch A=0 writes, B=0 -> all bit-0 outputs stay 0.
